// File: rtl/pic_host_bus_master.sv
// CPU-side bus master for an 8259-style PIC: ICW1-ICW4/OCW1 init, OCW1 mask writes, INTA_ service.
// Define PIC_HOST_EOI_EN to add a non-specific EOI (OCW2 = 8'h20) write after each vector capture.
module pic_host_bus_master #(
    parameter logic [7:0]  ICW1_VAL  = 8'h13,
    parameter logic [7:0]  ICW2_VAL  = 8'h20,
    parameter logic [7:0]  ICW3_VAL  = 8'h00,
    parameter logic [7:0]  ICW4_VAL  = 8'h01,
    parameter logic [7:0]  MASK_INIT = 8'h00,
    parameter int unsigned PULSE_W   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    output logic       o_init_done,
    output logic       o_busy,
    input  logic       i_mask_req,
    input  logic [7:0] i_mask_val,
    output logic       o_mask_ack,
    input  logic       i_int_in,
    output logic [7:0] o_vec_data,
    output logic       o_vec_valid,
    output logic       o_wr_en,
    output logic       o_rd_en,
    output logic       o_a0,
    output logic [7:0] o_data_out,
    output logic       o_data_oe,
    input  logic [7:0] i_data_in,
    output logic       o_inta_n
);

    typedef enum logic [3:0] {
        StIdle,
        StIcw1,
        StIcw2,
        StIcw3,
        StIcw4,
        StOcw1,
        StReady,
        StInta1,
        StInta2,
        StMask
`ifdef PIC_HOST_EOI_EN
        , StEoi
`endif
    } state_e;

    typedef enum logic [1:0] {
        PhSetup,
        PhStrobe,
        PhHold
    } phase_e;

    localparam logic [3:0] LAST_STROBE = 4'(PULSE_W - 1);
    localparam logic       SKIP_ICW3   = ICW1_VAL[1];
    localparam logic       HAS_ICW4    = ICW1_VAL[0];
    localparam logic [7:0] OCW2_EOI    = 8'h20;

    state_e     r_state;
    phase_e     r_phase;
    logic [3:0] r_cnt;
    logic [7:0] r_mask_data;
    logic [7:0] r_vec_data;
    logic       r_vec_valid;

    state_e     w_state_nxt;
    phase_e     w_phase_nxt;
    logic [3:0] w_cnt_nxt;
    logic       w_bus;
    logic       w_strobe;
    logic       w_mask_accept;
    logic       w_capture;
    logic       w_vec_done;

    assign w_bus    = (r_state != StIdle) && (r_state != StReady);
    assign w_strobe = w_bus && (r_phase == PhStrobe);

    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = r_phase;
        w_cnt_nxt     = r_cnt;
        w_mask_accept = 1'b0;
        w_capture     = 1'b0;
        w_vec_done    = 1'b0;
        if (!w_bus) begin
            w_phase_nxt = PhSetup;
            w_cnt_nxt   = 4'd0;
            // int_in outranks mask_req, which outranks start; only READY honours int/mask
            if (r_state == StReady && i_int_in) begin
                w_state_nxt = StInta1;
            end else if (r_state == StReady && i_mask_req) begin
                w_state_nxt   = StMask;
                w_mask_accept = 1'b1;
            end else if (i_start) begin
                w_state_nxt = StIcw1;
            end
        end else begin
            unique case (r_phase)
                PhSetup: begin
                    w_phase_nxt = PhStrobe;
                    w_cnt_nxt   = 4'd0;
                end
                PhStrobe: begin
                    if (r_cnt == LAST_STROBE) begin
                        w_phase_nxt = PhHold;
                        w_capture   = (r_state == StInta2);
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
                PhHold: begin
                    w_phase_nxt = PhSetup;
                    w_cnt_nxt   = 4'd0;
                    w_vec_done  = (r_state == StInta2);
                    case (r_state)
                        StIcw1:  w_state_nxt = StIcw2;
                        StIcw2:  w_state_nxt = !SKIP_ICW3 ? StIcw3 : (HAS_ICW4 ? StIcw4 : StOcw1);
                        StIcw3:  w_state_nxt = HAS_ICW4 ? StIcw4 : StOcw1;
                        StIcw4:  w_state_nxt = StOcw1;
                        StInta1: w_state_nxt = StInta2;
`ifdef PIC_HOST_EOI_EN
                        StInta2: w_state_nxt = StEoi;
`else
                        StInta2: w_state_nxt = StReady;
`endif
                        default: w_state_nxt = StReady;
                    endcase
                end
                default: w_phase_nxt = PhSetup;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_phase     <= PhSetup;
            r_cnt       <= 4'd0;
            r_mask_data <= 8'h00;
            r_vec_data  <= 8'h00;
            r_vec_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_cnt       <= w_cnt_nxt;
            r_vec_valid <= w_vec_done;
            if (w_mask_accept) begin
                r_mask_data <= i_mask_val;
            end
            if (w_capture) begin
                r_vec_data <= i_data_in;
            end
        end
    end

    // Pins decode straight from registered state so reset clears strobes without waiting a clock
    always_comb begin
        o_wr_en    = 1'b0;
        o_rd_en    = 1'b0;
        o_inta_n   = 1'b1;
        o_a0       = 1'b0;
        o_data_out = 8'h00;
        o_data_oe  = 1'b0;
        case (r_state)
            StIcw1: begin
                o_data_oe  = 1'b1;
                o_data_out = ICW1_VAL;
                o_wr_en    = w_strobe;
            end
            StIcw2: begin
                o_data_oe  = 1'b1;
                o_a0       = 1'b1;
                o_data_out = ICW2_VAL;
                o_wr_en    = w_strobe;
            end
            StIcw3: begin
                o_data_oe  = 1'b1;
                o_a0       = 1'b1;
                o_data_out = ICW3_VAL;
                o_wr_en    = w_strobe;
            end
            StIcw4: begin
                o_data_oe  = 1'b1;
                o_a0       = 1'b1;
                o_data_out = ICW4_VAL;
                o_wr_en    = w_strobe;
            end
            StOcw1: begin
                o_data_oe  = 1'b1;
                o_a0       = 1'b1;
                o_data_out = MASK_INIT;
                o_wr_en    = w_strobe;
            end
            StMask: begin
                o_data_oe  = 1'b1;
                o_a0       = 1'b1;
                o_data_out = r_mask_data;
                o_wr_en    = w_strobe;
            end
`ifdef PIC_HOST_EOI_EN
            StEoi: begin
                o_data_oe  = 1'b1;
                o_data_out = OCW2_EOI;
                o_wr_en    = w_strobe;
            end
`endif
            StInta1: o_inta_n = !w_strobe;
            StInta2: begin
                o_inta_n = !w_strobe;
                o_rd_en  = w_strobe;
            end
            default: ;
        endcase
    end

`ifdef PIC_HOST_EOI_EN
    assign o_init_done = (r_state == StReady) || (r_state == StInta1) || (r_state == StInta2)
                         || (r_state == StEoi);
`else
    assign o_init_done = (r_state == StReady) || (r_state == StInta1) || (r_state == StInta2);
`endif
    assign o_busy      = w_bus;
    assign o_mask_ack  = w_mask_accept;
    assign o_vec_data  = r_vec_data;
    assign o_vec_valid = r_vec_valid;

endmodule

// File: tb/tb_pic_host_bus_master.sv
// Randomised bench for pic_host_bus_master: queue-based transaction model plus directed literal checks.
module tb_pic_host_bus_master;

    localparam int unsigned P = 2;
`ifdef PIC_HOST_EOI_EN
    localparam int SVC = 3 * (P + 2) + 1;
`else
    localparam int SVC = 2 * (P + 2) + 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       mask_req = 1'b0;
    logic [7:0] mask_val = 8'h00;
    logic       int_in = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic       idone, busy, mack, vvalid, wr, rd, a0, oe, inta_n;
    logic [7:0] vdata, dout;
    logic       idone_p1, busy_p1, mack_p1, vvalid_p1, wr_p1, rd_p1, a0_p1, oe_p1, inta_n_p1;
    logic [7:0] vdata_p1, dout_p1;
    logic       idone_s, busy_s, mack_s, vvalid_s, wr_s, rd_s, a0_s, oe_s, inta_n_s;
    logic [7:0] vdata_s, dout_s;

    always #5 clk = ~clk;

    pic_host_bus_master u_dut (
        .clk(clk), .rst(rst), .i_start(start), .o_init_done(idone), .o_busy(busy),
        .i_mask_req(mask_req), .i_mask_val(mask_val), .o_mask_ack(mack), .i_int_in(int_in),
        .o_vec_data(vdata), .o_vec_valid(vvalid), .o_wr_en(wr), .o_rd_en(rd), .o_a0(a0),
        .o_data_out(dout), .o_data_oe(oe), .i_data_in(data_in), .o_inta_n(inta_n)
    );

    pic_host_bus_master #(.PULSE_W(1)) u_dut_p1 (
        .clk(clk), .rst(rst), .i_start(start), .o_init_done(idone_p1), .o_busy(busy_p1),
        .i_mask_req(mask_req), .i_mask_val(mask_val), .o_mask_ack(mack_p1), .i_int_in(int_in),
        .o_vec_data(vdata_p1), .o_vec_valid(vvalid_p1), .o_wr_en(wr_p1), .o_rd_en(rd_p1),
        .o_a0(a0_p1), .o_data_out(dout_p1), .o_data_oe(oe_p1), .i_data_in(data_in),
        .o_inta_n(inta_n_p1)
    );

    pic_host_bus_master #(.ICW1_VAL(8'h12)) u_dut_s (
        .clk(clk), .rst(rst), .i_start(start), .o_init_done(idone_s), .o_busy(busy_s),
        .i_mask_req(mask_req), .i_mask_val(mask_val), .o_mask_ack(mack_s), .i_int_in(int_in),
        .o_vec_data(vdata_s), .o_vec_valid(vvalid_s), .o_wr_en(wr_s), .o_rd_en(rd_s),
        .o_a0(a0_s), .o_data_out(dout_s), .o_data_oe(oe_s), .i_data_in(data_in),
        .o_inta_n(inta_n_s)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write logs: {a0, data} captured on every wr_en rising edge
    logic [8:0] log0[$];
    logic [8:0] log_p1[$];
    logic [8:0] log_s[$];
    always @(posedge wr)    log0.push_back({a0, dout});
    always @(posedge wr_p1) log_p1.push_back({a0_p1, dout_p1});
    always @(posedge wr_s)  log_s.push_back({a0_s, dout_s});

    // Model: one entry per expected bus clock for u_dut (default parameters)
    typedef struct packed {
        logic       wr;
        logic       rd;
        logic       inta_n;
        logic       oe;
        logic       a0;
        logic [7:0] d;
        logic       idone;
        logic       cap;
        logic       vdone;
    } ent_t;

    ent_t       sched[$];
    bit         m_rdy = 1'b0;
    logic [7:0] m_vec = 8'h00;
    bit         m_vv = 1'b0;

    task automatic push_bus(input bit is_wr, input bit wa0, input logic [7:0] wd, input bit is_rd,
                            input bit id, input bit svc2);
        ent_t e;
        for (int i = 0; i < int'(P) + 2; i++) begin
            bit strobe;
            strobe   = (i >= 1) && (i <= int'(P));
            e.wr     = is_wr && strobe;
            e.rd     = is_rd && strobe;
            e.inta_n = is_wr || !strobe;
            e.oe     = is_wr;
            e.a0     = wa0;
            e.d      = wd;
            e.idone  = id;
            e.cap    = svc2 && (i == int'(P));
            e.vdone  = svc2 && (i == int'(P) + 1);
            sched.push_back(e);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sched.delete();
            m_rdy = 1'b0;
            m_vec = 8'h00;
            m_vv  = 1'b0;
        end else begin
            m_vv = 1'b0;
            if (sched.size() != 0) begin
                ent_t e;
                e = sched.pop_front();
                if (e.cap) m_vec = data_in;
                if (e.vdone) m_vv = 1'b1;
            end else if (m_rdy && int_in) begin
                push_bus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
                push_bus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
`ifdef PIC_HOST_EOI_EN
                push_bus(1'b1, 1'b0, 8'h20, 1'b0, 1'b1, 1'b0);
`endif
            end else if (m_rdy && mask_req) begin
                push_bus(1'b1, 1'b1, mask_val, 1'b0, 1'b0, 1'b0);
            end else if (start) begin
                m_rdy = 1'b1;
                push_bus(1'b1, 1'b0, 8'h13, 1'b0, 1'b0, 1'b0);
                push_bus(1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
                push_bus(1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
                push_bus(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
            end
        end
    end

    // Per-cycle compare, 2 time units after the falling edge
    initial begin
        forever begin
            ent_t e;
            bit   ack_exp;
            @(negedge clk);
            #2;
            if (sched.size() != 0) begin
                e = sched[0];
            end else begin
                e = '{wr: 1'b0, rd: 1'b0, inta_n: 1'b1, oe: 1'b0, a0: 1'b0, d: 8'h00,
                      idone: m_rdy, cap: 1'b0, vdone: 1'b0};
            end
            ack_exp = (sched.size() == 0) && m_rdy && !int_in && mask_req && !rst;
            check("wr_rd_inta_oe_busy_idone", {wr, rd, inta_n, oe, busy, idone},
                  {e.wr, e.rd, e.inta_n, e.oe, sched.size() != 0, e.idone});
            if (e.oe) check("a0_data", {a0, dout}, {e.a0, e.d});
            check("mask_ack", mack, ack_exp);
            check("vec_valid", vvalid, m_vv);
            check("vec_data", vdata, m_vec);
        end
    end

    initial begin
        int c0, c1, cs, w0, w1, k_vv, n_low, n_rd, n_vv, n_fall, ack_k, n_busy;
        bit prev_n, found;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_pins", {wr, rd, inta_n, a0, dout, oe}, {1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0});
        check("rst_status", {vdata, vvalid, mack, idone, busy}, 12'h000);
        rst = 1'b0;

        // Init from IDLE on all three instances
        @(negedge clk);
        start = 1'b1;
        c0 = 0; c1 = 0; cs = 0; w0 = 0; w1 = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (c0 == 0 && idone) c0 = k;
            if (c1 == 0 && idone_p1) c1 = k;
            if (cs == 0 && idone_s) cs = k;
            w0 += int'(wr);
            w1 += int'(wr_p1);
        end
        check("init_latency_default", c0, 17);
        check("init_latency_pw1", c1, 13);
        check("init_latency_single", cs, 13);
        check("strobe_clocks_default", w0, 8);
        check("strobe_clocks_pw1", w1, 4);
        check("writes_default_n", log0.size(), 4);
        if (log0.size() == 4)
            check("writes_default", {log0[0], log0[1], log0[2], log0[3]},
                  {9'h013, 9'h120, 9'h101, 9'h100});
        check("writes_pw1_n", log_p1.size(), 4);
        if (log_p1.size() == 4)
            check("writes_pw1", {log_p1[0], log_p1[1], log_p1[2], log_p1[3]},
                  {9'h013, 9'h120, 9'h101, 9'h100});
        check("writes_single_n", log_s.size(), 3);
        if (log_s.size() == 3)
            check("writes_single", {log_s[0], log_s[1], log_s[2]}, {9'h012, 9'h120, 9'h100});
        log0.delete();

        // Interrupt service
        @(negedge clk);
        int_in = 1'b1;
        data_in = 8'h25;
        n_low = 0; n_rd = 0; n_vv = 0; n_fall = 0; k_vv = 0; prev_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            int_in = 1'b0;
            if (!inta_n) n_low++;
            if (rd) n_rd++;
            if (rd && inta_n) n_rd += 100;
            if (prev_n && !inta_n) n_fall++;
            prev_n = inta_n;
            if (vvalid) begin
                n_vv++;
                k_vv = k;
            end
        end
        check("inta_low_clocks", n_low, 2 * P);
        check("inta_pulses", n_fall, 2);
        check("rd_clocks", n_rd, P);
        check("vec_valid_clocks", n_vv, 1);
        check("vec_valid_when", k_vv, 2 * (P + 2) + 1);
        check("vec_data_25", vdata, 8'h25);
        check("vec_data_25_pw1", vdata_p1, 8'h25);
`ifdef PIC_HOST_EOI_EN
        check("eoi_write_n", log0.size(), 1);
        if (log0.size() == 1) check("eoi_write", log0[0], 9'h020);
`else
        check("no_eoi_write", log0.size(), 0);
`endif
        log0.delete();

        // int_in and mask_req in the same READY cycle
        @(negedge clk);
        int_in = 1'b1;
        mask_req = 1'b1;
        mask_val = 8'hF0;
        ack_k = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            int_in = 1'b0;
            if (ack_k != 0) mask_req = 1'b0;
            if (ack_k == 0 && mack) ack_k = k;
        end
        mask_req = 1'b0;
        check("mask_ack_when", ack_k, SVC);
        check("mask_write_n", log0.size() >= 1, 1);
        if (log0.size() >= 1) check("mask_write", log0[log0.size() - 1], 9'h1F0);

        // Reset during ICW2 strobe
        @(negedge clk);
        start = 1'b1;
        found = 1'b0;
        for (int k = 1; k <= 40 && !found; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (wr && a0) found = 1'b1;
        end
        check("icw2_strobe_found", found, 1);
        #1 rst = 1'b1;
        #1;
        check("wr_en_async_drop", {wr, busy, oe}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        n_busy = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            n_busy += int'(busy) + int'(wr) + int'(!inta_n) + int'(idone);
        end
        check("idle_after_reset", n_busy, 0);

        // Randomised traffic against the model
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            start    = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0) int_in = !int_in;
            if ($urandom_range(0, 5) == 0) mask_req = !mask_req;
            mask_val = 8'($urandom);
            data_in  = 8'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                #3 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pic_host_bus_master.md
# pic_host_bus_master

Clocked CPU-side bus master for the 8259-style PIC control unit. Performs the ICW1–ICW4 initialisation sequence and OCW1 mask writes on the PIC's write strobe. Services PIC interrupt requests with the two-pulse INTA_ handshake and returns the captured vector to the local host logic. Sits between the system sequencer/CPU model and the PIC's DATA/A0/WR_ENABLE/RD_ENABLE/INTA_ pins.

## Interface
- ICW1_VAL, 8'h13 — ICW1 byte; bit4 must be 1; bit1 = single (1 skips ICW3); bit0 = IC4 (0 skips ICW4)
- ICW2_VAL, 8'h20 — vector base; [7:3] form the upper vector bits
- ICW3_VAL, 8'h00 — cascade byte; written only when ICW1_VAL[1]=0
- ICW4_VAL, 8'h01 — written only when ICW1_VAL[0]=1
- MASK_INIT, 8'h00 — OCW1 written at the end of init
- PULSE_W, 2 — strobe-active cycles per bus cycle; legal range 1..13

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  level; sampled in IDLE and READY; begins or restarts init
- init_done  out  1  high in READY and while servicing an interrupt
- busy  out  1  high whenever a bus cycle is in progress
- mask_req  in  1  request an OCW1 write of mask_val
- mask_val  in  8  mask byte; captured when mask_ack pulses
- mask_ack  out  1  one-cycle pulse when the request is accepted
- int_in  in  1  PIC INT output
- vec_data  out  8  captured vector; holds until the next capture
- vec_valid  out  1  one-cycle pulse when vec_data updates
- wr_en  out  1  PIC WR_ENABLE; active high; PIC latches on the rising edge
- rd_en  out  1  PIC RD_ENABLE; active high; PIC drives DATA while it is high
- a0  out  1  PIC A0
- data_out  out  8  write data
- data_oe  out  1  tristate enable for data_out onto DATA
- data_in  in  8  DATA bus read-back
- inta_n  out  1  PIC INTA_; active low

## Operation
- States: IDLE → ICW1 → ICW2 → [ICW3] → [ICW4] → OCW1 → READY; READY → INTA1 → INTA2 → READY; READY → MASK → READY.
- Initialisation writes:
  - ICW1 uses a0=0.
  - ICW2, ICW3, ICW4, OCW1 and MASK use a0=1.
  - ICW3 is skipped when ICW1_VAL[1]=1.
  - ICW4 is skipped when ICW1_VAL[0]=0.
- READY arbitration: int_in=1 has priority over mask_req; mask_req has priority over start.
  - mask_req: mask_ack pulses in the acceptance cycle, and the MASK write then outputs mask_val.
  - start in READY restarts at ICW1. init_done drops in the first ICW1 cycle.
- INTA1: inta_n pulse only; data_in is ignored.
- INTA2: inta_n low and rd_en high together. data_in is sampled on the last strobe cycle into vec_data.
- Reset values:
  - wr_en=0, rd_en=0, inta_n=1, a0=0, data_out=0, data_oe=0.
  - vec_data=0, vec_valid=0, mask_ack=0, init_done=0, busy=0.
  - State = IDLE.
- Reset mid-cycle: all strobes return to inactive immediately (asynchronously). An aborted write is not re-issued. Full init is required again.
- int_in or mask_req arriving during init: ignored until READY is reached.
- int_in still high after returning to READY: a new INTA1 starts the next cycle.

## Timing
- Every bus cycle lasts PULSE_W+2 clocks, in three phases:
  - SETUP: 1 clock. a0, data_out and data_oe are valid; strobe inactive.
  - STROBE: PULSE_W clocks. wr_en=1, or inta_n=0 (INTA2 also has rd_en=1).
  - HOLD: 1 clock. Strobe inactive; a0 and data still driven.
- data_oe=1 during all three phases of write cycles only; 0 for INTA cycles.
- A new cycle's SETUP follows HOLD directly, with no gap.
- busy=1 from SETUP through HOLD.
- Init latency from start (sampled in IDLE) to init_done=1, with N = number of writes (3–5):
  - N·(PULSE_W+2)+1 clocks.
  - Defaults (ICW1, ICW2, ICW4, OCW1; N=4): 17 clocks.
- vec_valid pulses in the clock after INTA2 HOLD.
- Interrupt service without EOI: 2·(PULSE_W+2)+1 clocks from int_in being sampled high.

## Configuration
- PIC_HOST_EOI_EN defined:
  - After vec_valid, an EOI state writes OCW2 = 8'h20 (non-specific EOI) with a0=0, taking one bus cycle.
  - Return to READY follows that write.
  - Service latency grows by PULSE_W+2 clocks.
- Undefined:
  - INTA2 returns directly to READY; the PIC is expected to run in AEOI mode.
  - No EOI state exists.

## Test plan
- Default parameters, start pulse → wr_en rising edges carry {a0,data}:
  - writes = {0,13}, {1,20}, {1,01}, {1,00}
  - init_done=1 at clock 17
- ICW1_VAL=8'h12 (single, no IC4) → exactly two ICW writes ({0,12}, {1,20}), then OCW1; ICW3 and ICW4 absent.
- READY, int_in=1, data_in=8'h25 during INTA2 → two inta_n pulses of 2 clocks each, rd_en high only in the second, vec_data=8'h25 and vec_valid for 1 clock. With PIC_HOST_EOI_EN, this is followed by a {0,20} write.
- int_in and mask_req (mask_val=8'hF0) in the same READY cycle → INTA service first, then the 8'hF0 write with a0=1; mask_ack delayed until acceptance.
- rst asserted during ICW2 STROBE → wr_en falls in the same clock; after release, stays in IDLE with no bus activity until start.
- PULSE_W=1 → every strobe lasts exactly 1 clock; default init completes at clock 13.
